// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared constants and types for the integer core pipeline.
//   - DATA_W   : datapath width
//   - REG_AW   : register address width (register 0 reads as zero)
//   - fwd_sel_e: operand-forward source select (register file, EX/MEM, MEM/WB)
//   - REG_ZERO : address of the hardwired zero register
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Purely combinational operand-forward selector for one source register.
//   Picks the youngest in-flight producer of the source register:
//   EX/MEM first, then MEM/WB, otherwise the value read from the register
//   file in ID. A source address of zero never forwards, because the zero
//   register is not a real storage location.
//
// Ports:
//   src           in   source register address
//   exm_rd        in   EX/MEM destination address
//   exm_reg_write in   EX/MEM writes its destination
//   exm_result    in   EX/MEM ALU result
//   mwb_rd        in   MEM/WB destination address
//   mwb_reg_write in   MEM/WB writes its destination
//   mwb_result    in   MEM/WB writeback value
//   rf_data       in   latched register-file read value
//   value         out  forwarded operand value
//   sel           out  chosen source (fwd_sel_e)
// -----------------------------------------------------------------------------
module fwd_select
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [DATA_W-1:0] mwb_result,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] value,
  output fwd_sel_e          sel
);

  logic exm_hit;
  logic mwb_hit;

  // Checking the producer's rd against zero is enough to keep r0 from
  // forwarding: a match then requires src to be nonzero as well.
  assign exm_hit = exm_reg_write && (exm_rd != REG_AW'(REG_ZERO)) && (exm_rd == src);
  assign mwb_hit = mwb_reg_write && (mwb_rd != REG_AW'(REG_ZERO)) && (mwb_rd == src);

  always_comb begin
    sel   = FWD_RF;
    value = rf_data;
    if (exm_hit) begin
      sel   = FWD_EXM;
      value = exm_result;
    end else if (mwb_hit) begin
      sel   = FWD_MWB;
      value = mwb_result;
    end
  end

endmodule

// File: rtl/ex_operand_forward.sv
// -----------------------------------------------------------------------------
// ex_operand_forward
//   ID/EX pipeline register of the 5-stage core with operand forwarding and
//   load-use hazard detection.
//
//   The decoded ID fields are registered once per cycle. The ALU operands
//   presented to EX are built combinationally from those registered fields
//   and the live EX/MEM and MEM/WB writeback buses. When the instruction in
//   EX is a load whose destination is read by the instruction in ID, stall
//   is raised for one cycle and a bubble is loaded; the held ID instruction
//   then picks the load data up from MEM/WB on the following cycle.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   id_*                decoded instruction in ID (valid, addresses,
//                       register-file data, immediate, control)
//   flush               squash the ID entry (taken branch/jump)
//   exm_rd/_reg_write/_result  EX/MEM writeback bus
//   mwb_rd/_reg_write/_result  MEM/WB writeback bus
//   stall               hold PC and IF/ID this cycle
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read  registered EX control
//   ex_op_a, ex_op_b    forwarded ALU operands (op_b may be the immediate)
//   ex_store_data       forwarded rt value for stores
// -----------------------------------------------------------------------------
module ex_operand_forward
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              vld_p1;
  logic [REG_AW-1:0] rs_p1;
  logic [REG_AW-1:0] rt_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [DATA_W-1:0] rs_data_p1;
  logic [DATA_W-1:0] rt_data_p1;
  logic [DATA_W-1:0] imm_p1;
  logic              use_imm_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;

  logic              rs_dep;
  logic              rt_dep;
  logic              bubble;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;
  logic              unused_sel;

  // ---- ID side: load-use hazard on the instruction currently in ID ----
  // rt only counts as a dependency when operand B is actually the register.
  assign rs_dep = (rd_p1 == id_rs);
  assign rt_dep = (rd_p1 == id_rt) && !id_use_imm;

  assign stall = vld_p1 && mem_read_p1 && (rd_p1 != REG_AW'(REG_ZERO)) &&
                 id_valid && (rs_dep || rt_dep);

  // flush takes precedence, but both produce the same bubble, so they share
  // one path. The bubble only squashes control; the data fields are don't-care.
  assign bubble = flush || stall;

  // ---- ID/EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rd_p1        <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      imm_p1       <= '0;
      use_imm_p1   <= 1'b0;
    end else begin
      if (bubble) begin
        vld_p1       <= 1'b0;
        reg_write_p1 <= 1'b0;
        mem_read_p1  <= 1'b0;
      end else begin
        vld_p1       <= id_valid;
        reg_write_p1 <= id_reg_write;
        mem_read_p1  <= id_mem_read;
      end
      rs_p1      <= id_rs;
      rt_p1      <= id_rt;
      rd_p1      <= id_rd;
      rs_data_p1 <= id_rs_data;
      rt_data_p1 <= id_rt_data;
      imm_p1     <= id_imm;
      use_imm_p1 <= id_use_imm;
    end
  end

  // ---- EX side: forwarded operands from the registered fields ----
  fwd_select #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .src           (rs_p1),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .rf_data       (rs_data_p1),
    .value         (fwd_a),
    .sel           (sel_a)
  );

  fwd_select #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .src           (rt_p1),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .rf_data       (rt_data_p1),
    .value         (fwd_b),
    .sel           (sel_b)
  );

  // Select codes are only of interest when probing the design.
  assign unused_sel = ^{sel_a, sel_b};

  assign ex_valid      = vld_p1;
  assign ex_rd         = rd_p1;
  // An invalid slot must never write back or be mistaken for a load.
  assign ex_reg_write  = vld_p1 && reg_write_p1;
  assign ex_mem_read   = vld_p1 && mem_read_p1;
  assign ex_op_a       = fwd_a;
  assign ex_op_b       = use_imm_p1 ? imm_p1 : fwd_b;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_ex_operand_forward.sv
module tb_ex_operand_forward;
  import core_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_use_imm, id_reg_write, id_mem_read;
  logic              flush;
  logic [REG_AW-1:0] exm_rd, mwb_rd;
  logic              exm_reg_write, mwb_reg_write;
  logic [DATA_W-1:0] exm_result, mwb_result;
  logic              stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_store_data;

  int compared   = 0;
  int mismatched = 0;

  ex_operand_forward dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .flush         (flush),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_op_a       (ex_op_a),
    .ex_op_b       (ex_op_b),
    .ex_store_data (ex_store_data)
  );

  always #5 clk = ~clk;

  // One record: ID inputs, the writeback buses seen while the instruction
  // sits in EX, and the EX outputs expected in that cycle.
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        ui, rw, mr, v;
    logic [4:0]  erd;
    logic        ewe;
    logic [31:0] eres;
    logic [4:0]  mrd;
    logic        mwe;
    logic [31:0] mres;
    logic        xv;
    logic [4:0]  xrd;
    logic        xrw, xmr;
    logic [31:0] xa, xb, xs;
  } vec_t;

  vec_t tbl[10];
  vec_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_reg_write = 0; id_mem_read = 0;
  endtask

  task automatic idle_fwd();
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic ui, input logic rw, input logic mr, input logic v);
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = ui; id_reg_write = rw; id_mem_read = mr; id_valid = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 0);
    chk({tag, ".ex_rd"}, 32'(ex_rd), 0);
    chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 0);
    chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 0);
    chk({tag, ".op_a"}, ex_op_a, 0);
    chk({tag, ".op_b"}, ex_op_b, 0);
    chk({tag, ".store"}, ex_store_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    //         rs rt rd  rsd           rtd          imm           ui rw mr v   erd ewe eres          mrd mwe mres          xv xrd xrw xmr xa            xb            xs
    tbl[0] = '{20, 0,21, 32'h1234,     32'h0,       32'hff,       1, 1, 0, 1,  0, 0, 32'h0,        0, 0, 32'h0,        1, 21, 1, 0, 32'h1234,     32'hff,       32'h0};
    tbl[1] = '{21,22,23, 32'hBAD,      32'h100,     32'h0,        0, 1, 0, 1,  21,1, 32'h34,       0, 0, 32'h0,        1, 23, 1, 0, 32'h34,       32'h100,      32'h100};
    tbl[2] = '{8, 12,13, 32'h111,      32'h7,       32'h0,        0, 1, 0, 1,  5, 1, 32'h999,      8, 1, 32'h42,       1, 13, 1, 0, 32'h42,       32'h7,        32'h7};
    tbl[3] = '{8,  8, 9, 32'h1,        32'h1,       32'h0,        0, 1, 0, 1,  8, 1, 32'h5,        8, 1, 32'h9,        1, 9,  1, 0, 32'h5,        32'h5,        32'h5};
    tbl[4] = '{10, 9, 9, 32'h1000,     32'h0,       32'h0,        1, 1, 1, 1,  0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  1, 1, 32'h1000,     32'h0,        32'h0};
    tbl[5] = '{0,  0,10, 32'h0,        32'h0,       32'h0,        0, 1, 0, 1,  0, 1, 32'hDEAD,     0, 1, 32'hBEEF,     1, 10, 1, 0, 32'h0,        32'h0,        32'h0};
    tbl[6] = '{3,  4,14, 32'h30,       32'h40,      32'h0,        0, 1, 0, 1,  3, 0, 32'h1,        4, 0, 32'h2,        1, 14, 1, 0, 32'h30,       32'h40,       32'h40};
    tbl[7] = '{6,  7, 0, 32'h6,        32'h7,       32'hFFFFFFF0, 1, 0, 0, 1,  7, 1, 32'h77,       6, 1, 32'h66,       1, 0,  0, 0, 32'h66,       32'hFFFFFFF0, 32'h77};
    tbl[8] = '{1,  2, 5, 32'h11,       32'h22,      32'h0,        0, 1, 1, 0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 5,  0, 0, 32'h11,       32'h22,       32'h22};
    tbl[9] = '{15,16,17, 32'hA,        32'hB,       32'h0,        0, 1, 0, 1,  15,1, 32'hE0,       16,1, 32'hF0,       1, 17, 1, 0, 32'hE0,       32'hF0,       32'hF0};

    // Reset with a live instruction in ID: nothing may be latched.
    rst = 1; flush = 0; idle_fwd();
    set_id(5'd3, 5'd4, 5'd3, 32'h99, 32'h88, 32'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_zero("reset");
    chk("reset.stall", 32'(stall), 0);
    rst = 0; idle_id();

    // Table vectors through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_id(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rsd, tbl[i].rtd, tbl[i].imm,
             tbl[i].ui, tbl[i].rw, tbl[i].mr, tbl[i].v);
      idle_fwd();
      sbq.push_back(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      idle_id();
      e = sbq.pop_front();
      exm_rd = e.erd; exm_reg_write = e.ewe; exm_result = e.eres;
      mwb_rd = e.mrd; mwb_reg_write = e.mwe; mwb_result = e.mres;
      #1;
      chk($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(e.xv));
      chk($sformatf("v%0d.ex_rd", i), 32'(ex_rd), 32'(e.xrd));
      chk($sformatf("v%0d.ex_reg_write", i), 32'(ex_reg_write), 32'(e.xrw));
      chk($sformatf("v%0d.ex_mem_read", i), 32'(ex_mem_read), 32'(e.xmr));
      chk($sformatf("v%0d.op_a", i), ex_op_a, e.xa);
      chk($sformatf("v%0d.op_b", i), ex_op_b, e.xb);
      chk($sformatf("v%0d.store", i), ex_store_data, e.xs);
      chk($sformatf("v%0d.stall", i), 32'(stall), 0);
    end

    // Load-use: lw t1,0(t2) then add t3,t1,t1.
    @(negedge clk); idle_fwd();
    set_id(5'd10, 5'd9, 5'd9, 32'h2000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_id(5'd3, 5'd9, 5'd11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("lu.rt_imm_no_stall", 32'(stall), 0);
    id_use_imm = 0;
    #1 chk("lu.rt_reg_stall", 32'(stall), 1);
    id_valid = 0;
    #1 chk("lu.idle_no_stall", 32'(stall), 0);
    set_id(5'd9, 5'd9, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("lu.stall", 32'(stall), 1);
    chk("lu.load_in_ex", 32'(ex_mem_read), 1);
    @(posedge clk); @(negedge clk);
    exm_rd = 9; exm_reg_write = 1; exm_result = 32'h2000;
    #1 chk("lu.stall_once", 32'(stall), 0);
    chk("lu.bubble_valid", 32'(ex_valid), 0);
    chk("lu.bubble_rw", 32'(ex_reg_write), 0);
    chk("lu.bubble_mr", 32'(ex_mem_read), 0);
    @(posedge clk); @(negedge clk);
    idle_id(); idle_fwd();
    mwb_rd = 9; mwb_reg_write = 1; mwb_result = 32'hCAFEF00D;
    #1 chk("lu.add_valid", 32'(ex_valid), 1);
    chk("lu.add_rd", 32'(ex_rd), 11);
    chk("lu.add_op_a", ex_op_a, 32'hCAFEF00D);
    chk("lu.add_op_b", ex_op_b, 32'hCAFEF00D);

    // A load targeting r0 never stalls.
    @(negedge clk); idle_fwd();
    set_id(5'd10, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_id(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("r0load.stall", 32'(stall), 0);

    // Flush on the same edge as a load-use stall.
    @(negedge clk);
    set_id(5'd10, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_id(5'd9, 5'd8, 5'd11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    flush = 1;
    #1 chk("fs.stall", 32'(stall), 1);
    @(posedge clk); @(negedge clk);
    flush = 0;
    set_id(5'd3, 5'd4, 5'd5, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("fs.bubble_valid", 32'(ex_valid), 0);
    chk("fs.bubble_rw", 32'(ex_reg_write), 0);
    chk("fs.new_no_stall", 32'(stall), 0);
    @(posedge clk); @(negedge clk);
    idle_id();
    #1 chk("fs.new_valid", 32'(ex_valid), 1);
    chk("fs.new_rd", 32'(ex_rd), 5);
    chk("fs.new_op_a", ex_op_a, 32'h33);

    // Flush alone squashes an ordinary ALU instruction.
    @(negedge clk);
    set_id(5'd1, 5'd2, 5'd6, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    flush = 1;
    @(posedge clk); @(negedge clk);
    flush = 0; idle_id();
    #1 chk("fl.valid", 32'(ex_valid), 0);
    chk("fl.rw", 32'(ex_reg_write), 0);

    // Mid-run reset with a valid instruction in EX.
    @(negedge clk);
    set_id(5'd1, 5'd2, 5'd12, 32'h55, 32'h66, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    #1 chk("mr.pre_valid", 32'(ex_valid), 1);
    chk("mr.pre_op_a", ex_op_a, 32'h55);
    rst = 1;
    @(posedge clk); @(negedge clk);
    #1 chk_zero("midrst");
    rst = 0; idle_id();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_operand_forward.md
Name: ex_operand_forward

Overview:
ID/EX pipeline stage of the 5-stage core, with integrated operand forwarding and load-use hazard detection. Latches decoded operands from ID. Produces final ALU operands for EX by selecting the register-file value, the EX/MEM result or the MEM/WB result. Asserts a one-cycle stall toward IF/ID on a load-use dependency and inserts a bubble in that cycle.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width (32 registers; register 0 hardwired to zero)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source register A address
id_rt  in  REG_AW  source register B address
id_rd  in  REG_AW  destination register address
id_rs_data  in  DATA_W  register-file read A
id_rt_data  in  DATA_W  register-file read B
id_imm  in  DATA_W  sign/zero-extended immediate
id_use_imm  in  1  operand B comes from immediate
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
flush  in  1  branch/jump taken; squash ID entry
exm_rd  in  REG_AW  EX/MEM destination
exm_reg_write  in  1  EX/MEM writes rd
exm_result  in  DATA_W  EX/MEM ALU result
mwb_rd  in  REG_AW  MEM/WB destination
mwb_reg_write  in  1  MEM/WB writes rd
mwb_result  in  DATA_W  MEM/WB writeback value (ALU or load data)
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  registered valid of the EX-stage instruction
ex_rd  out  REG_AW  registered destination
ex_reg_write  out  1  registered; forced 0 when ex_valid=0
ex_mem_read  out  1  registered; forced 0 when ex_valid=0
ex_op_a  out  DATA_W  forwarded ALU operand A
ex_op_b  out  DATA_W  forwarded ALU operand B (or immediate)
ex_store_data  out  DATA_W  forwarded rt value, for stores

Behaviour:
- Reset: all ID/EX registers cleared, ex_valid=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, stall=0. Forwarded outputs then equal 0.
- Latency: one cycle from ID inputs to the registered EX fields. Forward muxes are combinational on the registered fields and the current exm_*/mwb_* inputs.
- Load-use detection (combinational): stall=1 when all of the following hold:
  - ex_valid=1 and ex_mem_read=1
  - ex_rd!=0
  - id_valid=1
  - ex_rd==id_rs, or ex_rd==id_rt with id_use_imm=0
- Clock-edge update priority:
  - rst: clear all.
  - else flush: load a bubble (valid=0, reg_write=0, mem_read=0). flush overrides stall; stall output is still the combinational value.
  - else stall: load a bubble. ID is held upstream and re-presented next cycle. A stall never lasts more than one consecutive cycle.
  - else: latch the ID fields, with valid=id_valid.
- Forward select, per source (rs→A, rt→B/store):
  - EX/MEM hit: exm_reg_write=1, exm_rd!=0, exm_rd==src. Value is exm_result.
  - else MEM/WB hit: mwb_reg_write=1, mwb_rd!=0, mwb_rd==src. Value is mwb_result.
  - else the latched register-file data.
  - EX/MEM has priority when both stages hit (youngest value wins).
- Operand B and store data:
  - ex_op_b = latched imm when use_imm=1, otherwise the forwarded rt value.
  - ex_store_data is always the forwarded rt value.
- Register 0: a source address of 0 never forwards. The latched rf data (zero) is used.
- Same-cycle writeback to a register read in ID is not handled here; the register file provides write-before-read.

Decomposition:
- Shared package core_pkg:
  - DATA_W and REG_AW constants
  - FWD_RF/FWD_EXM/FWD_MWB 2-bit select encoding
  - REG_ZERO constant
- Sub-module fwd_select: pure combinational. Inputs: source addr, exm/mwb rd/write/result, rf data. Outputs: value and select. Instantiated twice (rs, rt).

Test Plan:
- ALU→ALU: andi s5,s4,0xff (s4=0x1234) then slt s7,s5,s6 (s6=0x100) → second instr sees FWD_EXM, ex_op_a=0x34, no stall; s7=1.
- ALU→ALU distance 2: add t0 then an unrelated instr then sub using t0 → FWD_MWB selected for A. Double hit (exm_rd=mwb_rd=t0, results 5 and 9) → op_a=5.
- Load-use: lw t1,0(t2) then add t3,t1,t1 → stall=1 for exactly one cycle. Bubble has ex_valid=0 and ex_reg_write=0. Next cycle the add receives the load data via MEM/WB.
- Register zero: exm_rd=0 with exm_reg_write=1 and result 0xDEAD, consumer reads r0 → ex_op_a=0.
- Flush during stall: load-use condition plus flush=1 on the same edge → bubble latched. Next cycle stall=0 if ID is new.
- Mid-run rst=1 with a valid instruction in ID/EX → next edge: ex_valid=0 and all outputs 0.
